// File: rtl/hl_layer_sequencer.sv
// hl_layer_sequencer
// Drives one hidden layer of NUM_NEURONS neurons from a shared input stream.
// The input vector is held in a local buffer that can be written only while
// idle. Each element is broadcast once every neuron reports ready. The bench of
// neuron results is then collected, and the layer vector is presented with a
// one-cycle valid pulse and a sticky overflow flag.
//
// Optional feature: define HL_SEQ_TIMEOUT_EN to add TIMEOUT_CYCLES and timeout_o.
// The timeout watchdog covers the ready wait and the result collection. When it
// expires, the run ends early with a forced out_valid_o pulse.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   in_we_i/addr/data     input-buffer write port (honoured only when idle)
//   start_i               start-layer pulse (ignored while busy)
//   busy_o                high from accepted start until the result pulse
//   n_ready_i             per-neuron ready
//   n_value_in_o          broadcast element, qualified by n_valid_in_o
//   n_valid_in_o          one-cycle pulse per broadcast element
//   n_value_out_i         packed neuron results, neuron k at [k*WIDTH +: WIDTH]
//   n_valid_out_i         per-neuron result valid
//   n_overflow_i          per-neuron overflow
//   out_value_o           captured layer results, same packing
//   out_valid_o           one-cycle pulse, results complete
//   out_overflow_o        sticky OR of neuron overflows for the current run
//   timeout_o             (HL_SEQ_TIMEOUT_EN only) sticky timeout flag
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | buffer writable, waiting for start
// WAIT_RDY  | waiting for every neuron to be ready
// ISSUE     | broadcast buf[idx] for one cycle
// GAP       | one dead cycle so a stale ready is not taken for a fresh one
// COLLECT   | capture each neuron's first result
// DONE      | one-cycle result valid pulse
module hl_layer_sequencer #(
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_NEURONS = 8,
    parameter int WIDTH       = 8,
`ifdef HL_SEQ_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 1024,
`endif
    localparam int AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_we_i,
    input  logic [AW-1:0]                in_addr_i,
    input  logic [WIDTH-1:0]             in_data_i,
    input  logic                         start_i,
    output logic                         busy_o,
    input  logic [NUM_NEURONS-1:0]       n_ready_i,
    output logic [WIDTH-1:0]             n_value_in_o,
    output logic                         n_valid_in_o,
    input  logic [NUM_NEURONS*WIDTH-1:0] n_value_out_i,
    input  logic [NUM_NEURONS-1:0]       n_valid_out_i,
    input  logic [NUM_NEURONS-1:0]       n_overflow_i,
    output logic [NUM_NEURONS*WIDTH-1:0] out_value_o,
    output logic                         out_valid_o,
    output logic                         out_overflow_o
`ifdef HL_SEQ_TIMEOUT_EN
    ,
    output logic                         timeout_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_ISSUE, S_GAP, S_COLLECT, S_DONE
    } state_t;

    state_t                         state_q;
    logic [WIDTH-1:0]               buf_q [NUM_INPUTS];
    logic [AW-1:0]                  idx_q;
    logic [NUM_NEURONS-1:0]         mask_q;
    logic [NUM_NEURONS-1:0]         mask_d;
    logic [WIDTH-1:0]               n_value_q;
    logic                           n_valid_q;
    logic [NUM_NEURONS*WIDTH-1:0]   out_value_q;
    logic                           out_valid_q;
    logic                           ovf_q;
    logic                           ovf_live;
    logic                           addr_ok;

    // Overflow is accumulated from the first issue onwards. The only WAIT_RDY
    // cycles with idx 0 are the ones before element 0 has issued.
    always_comb begin
        mask_d   = mask_q | n_valid_out_i;
        ovf_live = (state_q != S_IDLE) && !((state_q == S_WAIT_RDY) && (idx_q == '0));
        addr_ok  = (32'(in_addr_i) < NUM_INPUTS);
    end

`ifdef HL_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          timeout_q;
    logic          tmo_hit;
    assign tmo_hit   = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_o = timeout_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NUM_INPUTS; i++) buf_q[i] <= '0;
            idx_q       <= '0;
            mask_q      <= '0;
            n_value_q   <= '0;
            n_valid_q   <= 1'b0;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef HL_SEQ_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            n_valid_q   <= 1'b0;
            out_valid_q <= 1'b0;
            if (ovf_live) ovf_q <= ovf_q | (|n_overflow_i);
`ifdef HL_SEQ_TIMEOUT_EN
            if (state_q == S_WAIT_RDY || state_q == S_COLLECT) tmo_cnt_q <= tmo_cnt_q + TW'(1);
`endif
            case (state_q)
                S_IDLE: begin
                    if (in_we_i && addr_ok) buf_q[in_addr_i] <= in_data_i;
                    if (start_i) begin
                        mask_q      <= '0;
                        ovf_q       <= 1'b0;
                        out_value_q <= '0;
                        idx_q       <= '0;
                        state_q     <= S_WAIT_RDY;
`ifdef HL_SEQ_TIMEOUT_EN
                        tmo_cnt_q   <= '0;
                        timeout_q   <= 1'b0;
`endif
                    end
                end
                S_WAIT_RDY: begin
                    if (&n_ready_i) begin
                        n_valid_q <= 1'b1;
                        n_value_q <= buf_q[idx_q];
                        state_q   <= S_ISSUE;
                    end
`ifdef HL_SEQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        timeout_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
`endif
                end
                S_ISSUE: begin
                    if (idx_q == AW'(NUM_INPUTS - 1)) begin
                        state_q <= S_COLLECT;
                    end else begin
                        idx_q   <= idx_q + AW'(1);
                        state_q <= S_GAP;
                    end
`ifdef HL_SEQ_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                S_GAP: begin
                    state_q <= S_WAIT_RDY;
`ifdef HL_SEQ_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                S_COLLECT: begin
                    // First capture wins: only slices not yet in the mask load.
                    for (int k = 0; k < NUM_NEURONS; k++) begin
                        if (n_valid_out_i[k] && !mask_q[k])
                            out_value_q[k*WIDTH +: WIDTH] <= n_value_out_i[k*WIDTH +: WIDTH];
                    end
                    mask_q <= mask_d;
                    if (&mask_d) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
`ifdef HL_SEQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        timeout_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
`endif
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o         = (state_q != S_IDLE);
    assign n_value_in_o   = n_value_q;
    assign n_valid_in_o   = n_valid_q;
    assign out_value_o    = out_value_q;
    assign out_valid_o    = out_valid_q;
    assign out_overflow_o = ovf_q;

endmodule

// File: tb/tb_hl_layer_sequencer.sv
module tb_hl_layer_sequencer;
    localparam int NI = 4;
    localparam int NN = 2;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_we;
    logic [1:0]      in_addr;
    logic [W-1:0]    in_data;
    logic            start;
    logic            busy;
    logic [NN-1:0]   n_ready;
    logic [W-1:0]    n_value_in;
    logic            n_valid_in;
    logic [NN*W-1:0] n_value_out;
    logic [NN-1:0]   n_valid_out;
    logic [NN-1:0]   n_overflow;
    logic [NN*W-1:0] out_value;
    logic            out_valid;
    logic            out_overflow;

    hl_layer_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .in_we_i(in_we), .in_addr_i(in_addr), .in_data_i(in_data),
        .start_i(start), .busy_o(busy), .n_ready_i(n_ready), .n_value_in_o(n_value_in),
        .n_valid_in_o(n_valid_in), .n_value_out_i(n_value_out), .n_valid_out_i(n_valid_out),
        .n_overflow_i(n_overflow), .out_value_o(out_value), .out_valid_o(out_valid),
        .out_overflow_o(out_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] iss_val[$];
    int         iss_cyc[$];
    int         ov_cnt = 0;
    always @(negedge clk) begin
        if (n_valid_in) begin
            iss_val.push_back(n_value_in);
            iss_cyc.push_back(cyc);
        end
        if (out_valid) ov_cnt++;
    end

    int errors = 0;
    int checks = 0;
    int exp_ov = 0;

    typedef struct packed {
        logic [31:0] bufv;     // element i at [8*i +: 8]
        logic [15:0] res;      // neuron results driven back
        logic [1:0]  ovf;      // overflow bits driven during collection
        logic [15:0] exp_val;
        logic        exp_ovf;
    } vec_t;
    vec_t vecs[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] v);
        for (int i = 0; i < NI; i++) begin
            in_we   = 1'b1;
            in_addr = 2'(i);
            in_data = v[8*i +: 8];
            tick();
        end
        in_we = 1'b0;
    endtask

    task automatic start_run();
        iss_val.delete();
        iss_cyc.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_issues(input int n, input string nm);
        int b = 0;
        while (iss_val.size() < n && b < 200) begin
            tick();
            b++;
        end
        if (iss_val.size() < n) chk({nm, "_issue_timeout"}, 64'(iss_val.size()), 64'(n));
    endtask

    // Called with the sequencer in ISSUE of the last element; returns with it in DONE.
    task automatic collect(input logic [15:0] res, input logic [1:0] ovf);
        tick();
        n_value_out = res;
        n_valid_out = 2'b11;
        n_overflow  = ovf;
        tick();
        n_valid_out = '0;
        n_overflow  = '0;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        load(v.bufv);
        start_run();
        chk($sformatf("v%0d_busy_at_start", k), 64'(busy), 64'(1));
        chk($sformatf("v%0d_ovf_cleared", k), 64'(out_overflow), 64'(0));
        chk($sformatf("v%0d_value_cleared", k), 64'(out_value), 64'(0));
        wait_issues(NI, $sformatf("v%0d", k));
        for (int i = 0; i < NI && i < iss_val.size(); i++) begin
            chk($sformatf("v%0d_issue%0d_value", k, i), 64'(iss_val[i]), 64'(v.bufv[8*i +: 8]));
            if (i > 0) chk($sformatf("v%0d_issue%0d_spacing", k, i), 64'(iss_cyc[i] - iss_cyc[i-1]), 64'(3));
        end
        collect(v.res, v.ovf);
        exp_ov++;
        chk($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'(1));
        chk($sformatf("v%0d_out_value", k), 64'(out_value), 64'(v.exp_val));
        chk($sformatf("v%0d_out_overflow", k), 64'(out_overflow), 64'(v.exp_ovf));
        tick();
        chk($sformatf("v%0d_valid_pulse_end", k), 64'(out_valid), 64'(0));
        chk($sformatf("v%0d_busy_end", k), 64'(busy), 64'(0));
        tick();
        chk($sformatf("v%0d_value_held", k), 64'(out_value), 64'(v.exp_val));
        chk($sformatf("v%0d_ovf_held", k), 64'(out_overflow), 64'(v.exp_ovf));
        chk($sformatf("v%0d_single_valid", k), 64'(ov_cnt), 64'(exp_ov));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        vecs[0] = '{bufv: 32'h04F81008, res: 16'hE012, ovf: 2'b00, exp_val: 16'hE012, exp_ovf: 1'b0};
        vecs[1] = '{bufv: 32'h7F80FF01, res: 16'h807F, ovf: 2'b01, exp_val: 16'h807F, exp_ovf: 1'b1};
        vecs[2] = '{bufv: 32'hAA550000, res: 16'h0001, ovf: 2'b10, exp_val: 16'h0001, exp_ovf: 1'b1};

        rst = 1'b1; in_we = 1'b0; in_addr = '0; in_data = '0; start = 1'b0;
        n_ready = 2'b11; n_value_out = '0; n_valid_out = '0; n_overflow = '0;

        // Reset then idle
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_value", 64'(out_value), 64'(0));
        chk("rst_out_overflow", 64'(out_overflow), 64'(0));
        chk("rst_n_value_in", 64'(n_value_in), 64'(0));
        chk("rst_no_issue", 64'(iss_val.size()), 64'(0));
        chk("rst_no_out_valid", 64'(ov_cnt), 64'(0));

        // Table-driven complete runs
        for (int k = 0; k < 3; k++) run_vec(k, vecs[k]);

        // Ready back-pressure before element 2
        load(32'h04030201);
        start_run();
        wait_issues(2, "bp");
        n_ready = 2'b01;
        repeat (10) tick();
        c = cyc;
        n_ready = 2'b11;
        wait_issues(NI, "bp");
        chk("bp_issue_count", 64'(iss_val.size()), 64'(NI));
        if (iss_val.size() >= 3) chk("bp_elem2_latency", 64'(iss_cyc[2] - c), 64'(1));
        for (int i = 0; i < NI && i < iss_val.size(); i++)
            chk($sformatf("bp_issue%0d_value", i), 64'(iss_val[i]), 64'(i + 1));
        collect(16'h5A5A, 2'b00);
        exp_ov++;
        chk("bp_out_value", 64'(out_value), 64'h5A5A);
        tick();

        // Out-of-order and duplicate results
        load(32'h00000000);
        start_run();
        wait_issues(NI, "ooo");
        tick();
        n_value_out = 16'h3300;
        n_valid_out = 2'b10;
        tick();
        n_valid_out = '0;
        chk("ooo_partial_no_valid", 64'(out_valid), 64'(0));
        repeat (3) tick();
        chk("ooo_still_busy", 64'(busy), 64'(1));
        chk("ooo_wait_no_valid", 64'(out_valid), 64'(0));
        tick();
        n_value_out = 16'h5544;
        n_valid_out = 2'b01;
        tick();
        exp_ov++;
        chk("ooo_out_valid", 64'(out_valid), 64'(1));
        chk("ooo_out_value", 64'(out_value), 64'h3344);
        n_value_out = 16'h9944;
        n_valid_out = 2'b10;
        tick();
        n_valid_out = '0;
        chk("ooo_valid_pulse_end", 64'(out_valid), 64'(0));
        chk("ooo_dup_ignored", 64'(out_value), 64'h3344);
        chk("ooo_single_valid", 64'(ov_cnt), 64'(exp_ov));

        // START / IN_WE during a run, overflow during COLLECT
        load(32'hDDCCBBAA);
        start_run();
        wait_issues(1, "grd");
        start = 1'b1; in_we = 1'b1; in_addr = 2'd0; in_data = 8'hEE;
        tick();
        start = 1'b0; in_we = 1'b0;
        wait_issues(NI, "grd");
        chk("grd_issue_count", 64'(iss_val.size()), 64'(NI));
        for (int i = 0; i < NI && i < iss_val.size(); i++)
            chk($sformatf("grd_issue%0d_value", i), 64'(iss_val[i]), 64'(8'hAA + 8'(i * 8'h11)));
        tick();
        n_overflow = 2'b01;
        tick();
        n_overflow = 2'b00;
        chk("grd_ovf_set", 64'(out_overflow), 64'(1));
        chk("grd_no_valid_yet", 64'(out_valid), 64'(0));
        n_value_out = 16'h2211;
        n_valid_out = 2'b11;
        tick();
        n_valid_out = '0;
        exp_ov++;
        chk("grd_out_valid", 64'(out_valid), 64'(1));
        repeat (3) tick();
        chk("grd_ovf_sticky", 64'(out_overflow), 64'(1));
        chk("grd_idle", 64'(busy), 64'(0));
        start_run();
        chk("grd_ovf_cleared", 64'(out_overflow), 64'(0));
        wait_issues(NI, "grd2");
        if (iss_val.size() >= 1) chk("grd_buf_unchanged", 64'(iss_val[0]), 64'hAA);
        collect(16'h0000, 2'b00);
        exp_ov++;
        tick();

        // Reset mid-run during COLLECT
        load(32'h44332211);
        start_run();
        wait_issues(NI, "mrst");
        tick();
        n_value_out = 16'h5566;
        n_valid_out = 2'b01;
        tick();
        n_overflow = 2'b11;
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_out_value", 64'(out_value), 64'(0));
        chk("mrst_out_valid", 64'(out_valid), 64'(0));
        chk("mrst_out_overflow", 64'(out_overflow), 64'(0));
        chk("mrst_n_valid_in", 64'(n_valid_in), 64'(0));
        chk("mrst_n_value_in", 64'(n_value_in), 64'(0));
        n_overflow = '0;
        tick();
        rst = 1'b0;
        n_valid_out = 2'b11;
        repeat (3) tick();
        n_valid_out = '0;
        chk("mrst_no_out_valid", 64'(ov_cnt), 64'(exp_ov));
        chk("mrst_idle", 64'(busy), 64'(0));
        start_run();
        wait_issues(NI, "mrst2");
        for (int i = 0; i < NI && i < iss_val.size(); i++)
            chk($sformatf("mrst_issue%0d_cleared", i), 64'(iss_val[i]), 64'(0));
        collect(16'h7788, 2'b00);
        exp_ov++;
        chk("mrst_rerun_valid", 64'(out_valid), 64'(1));
        chk("mrst_rerun_value", 64'(out_value), 64'h7788);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hl_layer_sequencer.md
Name: hl_layer_sequencer

Overview:
Sequences one hidden layer of NUM_NEURONS neuron instances that share a broadcast input stream. Holds the input vector in a local buffer, broadcasts one element per issue once every neuron reports ready, then collects each neuron's result. Presents the full layer output vector with a one-cycle valid pulse and a sticky overflow flag. Sits between the input loader (or previous layer) and a bank of hidden-layer neurons.

Parameters:
NUM_INPUTS, 16, elements per input vector (inputs per neuron), >=1
NUM_NEURONS, 8, neurons in the layer, >=1
WIDTH, 8, signed fixed-point data width

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  asynchronous, active-high reset
IN_WE  in  1  input-buffer write strobe
IN_ADDR  in  clog2(NUM_INPUTS)  input-buffer write address
IN_DATA  in  WIDTH  input-buffer write data, signed
START  in  1  start-layer pulse
BUSY  out  1  high from accepted START until OUT_VALID
N_READY  in  NUM_NEURONS  per-neuron ready
N_VALUE_IN  out  WIDTH  broadcast value to all neurons
N_VALID_IN  out  1  broadcast valid, one-cycle pulse per element
N_VALUE_OUT  in  NUM_NEURONS*WIDTH  packed neuron results, neuron k at [k*WIDTH +: WIDTH]
N_VALID_OUT  in  NUM_NEURONS  per-neuron result valid
N_OVERFLOW  in  NUM_NEURONS  per-neuron overflow
OUT_VALUE  out  NUM_NEURONS*WIDTH  captured layer results, same packing
OUT_VALID  out  1  one-cycle pulse, results complete
OUT_OVERFLOW  out  1  sticky OR of neuron overflows for the current run

Behaviour:
- Reset (async, RST=1):
  - FSM -> IDLE.
  - Input buffer, OUT_VALUE, capture mask and element index -> 0.
  - BUSY, N_VALID_IN, OUT_VALID, OUT_OVERFLOW -> 0.
  - N_VALUE_IN -> 0.
  - Reset mid-run aborts silently; no OUT_VALID is produced.
- Buffer write: when IN_WE=1 and the FSM is IDLE, buf[IN_ADDR] <= IN_DATA. Writes outside IDLE are dropped. Writes with IN_ADDR >= NUM_INPUTS are dropped.
- FSM states:
  - IDLE: when START=1, clear capture mask, OUT_OVERFLOW, OUT_VALUE and index, then go to WAIT_RDY. START in any other state is ignored.
  - WAIT_RDY: when &N_READY=1, go to ISSUE.
  - ISSUE (1 cycle): N_VALID_IN=1, N_VALUE_IN=buf[idx].
    - If idx==NUM_INPUTS-1, go to COLLECT.
    - Otherwise idx++ and go to GAP.
  - GAP (1 cycle): no issue; guards against stale READY. Then go to WAIT_RDY.
  - COLLECT: for each k with N_VALID_OUT[k]=1 and mask[k]=0, capture OUT_VALUE slice k <= N_VALUE_OUT slice k and set mask[k]. When the mask will be all ones, go to DONE.
  - DONE (1 cycle): OUT_VALID=1, then go to IDLE.
- Issue timing: minimum 3 cycles per element (WAIT_RDY, ISSUE, GAP) when neurons stay ready.
- N_VALUE_IN holds its last value outside ISSUE. Downstream qualifies it only by N_VALID_IN.
- N_VALID_OUT outside COLLECT is ignored. A repeat N_VALID_OUT for an already-captured neuron is ignored (first capture wins).
- Several N_VALID_OUT bits may assert in the same cycle; all are captured that cycle.
- OUT_OVERFLOW: from ISSUE of element 0 through DONE, OUT_OVERFLOW <= OUT_OVERFLOW | (|N_OVERFLOW). It is held after DONE until the next START.
- OUT_VALUE is held stable from DONE until the next START.
- BUSY = (state != IDLE).
- No arithmetic is performed; all data moves at WIDTH bits without modification.

Optional Feature:
Macro HL_SEQ_TIMEOUT_EN.
- Defined:
  - Add parameter TIMEOUT_CYCLES (default 1024) and output TIMEOUT (1 bit, reset 0).
  - A counter restarts on entry to WAIT_RDY and on entry to COLLECT, and increments each cycle spent in those states.
  - On reaching TIMEOUT_CYCLES: set TIMEOUT=1 (sticky until next START), force OUT_VALID=1 for one cycle with uncaptured slices left at 0, then go to IDLE.
- Not defined: no counter and no TIMEOUT port; the FSM waits indefinitely.

Test Plan:
- Reset then idle: RST pulse with START=0 -> BUSY=0, OUT_VALID=0, OUT_VALUE=0, N_VALID_IN never asserts.
- Basic run (NUM_INPUTS=4, NUM_NEURONS=2, all ready): load buf={8'h08,8'h10,8'hF8,8'h04}, START -> N_VALID_IN pulses with those values in order, 3 cycles apart; neurons return 8'h12 and 8'hE0 -> OUT_VALUE={8'hE0,8'h12}, single OUT_VALID, OUT_OVERFLOW=0.
- Ready back-pressure: N_READY[1]=0 for 10 cycles before element 2 -> element 2 issues exactly 1 cycle after N_READY goes to all ones; no element dropped or duplicated.
- Out-of-order and duplicate results: neuron 1 valid at cycle t, neuron 0 at t+5, neuron 1 again at t+6 with a different value -> first values kept, OUT_VALID one cycle after the last new capture.
- Overflow and guards: N_OVERFLOW[0]=1 for 1 cycle during COLLECT -> OUT_OVERFLOW=1 until next START. START and IN_WE during BUSY -> no effect on the run or the buffer contents.
- Reset mid-run: RST asserted during COLLECT -> all outputs 0, FSM IDLE, no OUT_VALID. A following START runs normally with the buffer cleared (N_VALUE_IN=0 for all elements).
